ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter WORD_W, default 8, width of each incoming bitstream word.
REQ-002 Parameter CHAIN_LEN, default 52, number of configuration flip-flops in the downstream ccff chain (7 size4 muxes x 6 bits + 5 size2 muxes x 2 bits).
REQ-003 Parameter CNT_W, default $clog2(CHAIN_LEN+1), width of the chain bit counter.
REQ-004 prog_clk  in  1  programming clock; the only clock in the block.
REQ-005 pReset_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 start  in  1  one-cycle request to begin a chain load; ignored unless the block is IDLE.
REQ-007 abort  in  1  terminates any load in progress and returns the block to IDLE.
REQ-008 cfg_data  in  WORD_W  bitstream word; MSB is shifted first.
REQ-009 cfg_valid  in  1  cfg_data is valid.
REQ-010 cfg_ready  out  1  the block accepts cfg_data this cycle.
REQ-011 ccff_head  out  1  serial data into the head of the configuration chain.
REQ-012 ccff_tail  in  1  serial data from the tail of the configuration chain.
REQ-013 shift_en  out  1  clock enable for the chain; the chain shifts at each prog_clk edge where shift_en=1.
REQ-014 busy  out  1  high in every state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on completion of a load.
REQ-016 tail_parity  out  1  XOR of all ccff_tail bits sampled during the last load, i.e. parity of the previous chain contents.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, SHIFT and DONE.
REQ-018 IDLE: start=1 SHALL move the FSM to FETCH, clear the bit counter, and clear tail_parity.
REQ-019 FETCH: cfg_ready SHALL be 1, and cfg_ready SHALL be 0 in every other state.
REQ-020 FETCH: when cfg_valid and cfg_ready are both 1, the block SHALL load cfg_data into the shift register, set the word-bit counter to min(WORD_W, CHAIN_LEN - bits shifted), and move to SHIFT.
REQ-021 SHIFT: shift_en SHALL be 1, ccff_head SHALL equal the shift register MSB, and each cycle SHALL left-shift the register, increment the bit counter and decrement the word-bit counter.
REQ-022 On the last shift cycle of a word: if the bit counter reaches CHAIN_LEN, the FSM SHALL go to DONE, otherwise it SHALL go to FETCH.
REQ-023 DONE: done SHALL be 1 for exactly one cycle, after which the FSM SHALL go to IDLE.
REQ-024 A partial final word SHALL shift only its upper CHAIN_LEN mod WORD_W bits; its remaining low bits SHALL be discarded.
REQ-025 shift_en and ccff_head SHALL be driven directly from flops (state decode plus shift register MSB) with no combinational path from any input.
REQ-026 On every cycle with shift_en=1, tail_parity SHALL be updated as tail_parity ^ ccff_tail.
REQ-027 If cfg_valid is low in FETCH, the block SHALL wait with shift_en=0, and the chain SHALL hold its contents.
REQ-028 abort SHALL take priority over every other event: on the next edge the FSM SHALL be in IDLE with shift_en=0, and done SHALL NOT pulse.
REQ-029 If start and abort are asserted together in IDLE, the FSM SHALL stay in IDLE.
REQ-030 Exactly CHAIN_LEN shift_en cycles SHALL occur per completed load, and exactly ceil(CHAIN_LEN/WORD_W) words SHALL be accepted.
REQ-031 With cfg_valid held high, the total latency from start to done SHALL be 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles.

Reset
REQ-032 Assertion of pReset_n (low) SHALL asynchronously force the FSM to IDLE; this SHALL hold even mid-load, and the chain contents are then undefined.
REQ-033 During reset: shift_en=0, ccff_head=0, cfg_ready=0, busy=0, done=0, tail_parity=0, and both counters and the shift register SHALL be 0.
REQ-034 Deassertion of pReset_n SHALL be synchronized to prog_clk externally; the block SHALL require no delay before start is asserted.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the default WORD_W and CHAIN_LEN constants, so that the chain length for each connection block is defined in one place.
REQ-036 The datapath (shift register, word-bit counter, tail parity) SHALL be implemented as one sub-module, ccff_loader_shifter; the FSM and the chain bit counter SHALL remain in the top module.

Verification
REQ-037 Streaming load: cfg_valid held high with words 0xA5,0x3C,0xFF,0x00,0x81,0x7E,0x9F and a 52-bit chain model -> model contents equal the first 52 MSB-first bits, the low nibble of 0x9F is discarded, 52 shift_en cycles occur, and done pulses at cycle 60 after start.
REQ-038 Back-pressure: cfg_valid deasserted for 5 cycles before word 3 -> shift_en stays 0 during the gap, the final chain contents match REQ-037, and done pulses at cycle 65.
REQ-039 Parity: preload the chain model with 52 bits containing 13 ones, then run a load -> tail_parity=1 after done.
REQ-040 Abort: abort asserted on shift cycle 20 -> next cycle shift_en=0, busy=0 and cfg_ready=0; done is never asserted.
REQ-041 Reset mid-load: pReset_n driven low on shift cycle 30 -> all outputs take their REQ-033 values immediately without waiting for a clock edge, and a new start then completes normally.
REQ-042 start pulses while busy -> ignored, with no change in the word count or shift count.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff chain loader: FSM state encoding and the
// default word width / chain length used by every connection block.
package ccff_loader_pkg;

  localparam int DEF_WORD_W    = 8;
  localparam int DEF_CHAIN_LEN = 52;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_FETCH = FETCH,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_e;

  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/ccff_loader_shifter.sv
// Datapath of the ccff loader: MSB-first word shift register, per-word bit
// counter and running parity of the bits leaving the chain tail.
module ccff_loader_shifter
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BITS_W = $clog2(DEF_WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] data,
  input  logic [BITS_W-1:0] load_bits,
  input  logic              tail,
  output logic              head,
  output logic              last_bit,
  output logic              parity
);

  logic [WORD_W-1:0] sreg_r;
  logic [BITS_W-1:0] bits_r;
  logic              parity_r;

  // Word register and remaining-bit count; a partial word just stops early.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg_r <= {WORD_W{1'b0}};
      bits_r <= {BITS_W{1'b0}};
    end else if (load) begin
      sreg_r <= data;
      bits_r <= load_bits;
    end else if (shift) begin
      sreg_r <= sreg_r << 1;
      bits_r <= bits_r - BITS_W'(1);
    end else begin
      sreg_r <= sreg_r;
      bits_r <= bits_r;
    end
  end

  // Parity of the previous chain contents, accumulated as they fall out.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      parity_r <= 1'b0;
    end else if (clear) begin
      parity_r <= 1'b0;
    end else if (shift) begin
      parity_r <= parity_step(parity_r, tail);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign head     = sreg_r[WORD_W-1];
  assign last_bit = (bits_r == BITS_W'(1));
  assign parity   = parity_r;

endmodule

// File: rtl/ccff_loader.sv
// Loads a configuration flip-flop chain from a word stream: fetches words,
// serialises them MSB first onto ccff_head and pulses done after CHAIN_LEN bits.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int BITS_W = $clog2(WORD_W + 1);

  state_e             state_r;
  state_e             state_nx;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   remain_s;
  logic [BITS_W-1:0]  load_bits_s;
  logic               clear_s;
  logic               accept_s;
  logic               last_bit_s;
  logic               shift_en_r;
  logic               cfg_ready_r;
  logic               busy_r;
  logic               done_r;

  assign accept_s = cfg_ready_r & cfg_valid & ~abort;

  // Bits to take from the next word: a whole word, or what is left of the chain.
  always_comb begin
    remain_s = CNT_W'(CHAIN_LEN) - bit_cnt_r;
    if (32'(remain_s) < 32'(WORD_W)) begin
      load_bits_s = BITS_W'(remain_s);
    end else begin
      load_bits_s = BITS_W'(WORD_W);
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_nx = state_r;
    clear_s  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nx = ST_FETCH;
            clear_s  = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (cfg_valid) begin
            state_nx = ST_SHIFT;
          end else begin
            state_nx = ST_FETCH;
          end
        end
        ST_SHIFT: begin
          if (!last_bit_s) begin
            state_nx = ST_SHIFT;
          end else if (bit_cnt_r + CNT_W'(1) == CNT_W'(CHAIN_LEN)) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_FETCH;
          end
        end
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // State register and output flops, all decoded from the next state.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_r     <= ST_IDLE;
      shift_en_r  <= 1'b0;
      cfg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      shift_en_r  <= (state_nx == ST_SHIFT);
      cfg_ready_r <= (state_nx == ST_FETCH);
      busy_r      <= (state_nx != ST_IDLE);
      done_r      <= (state_nx == ST_DONE);
    end
  end

  // Chain bit counter: total bits shifted since start.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (shift_en_r && !abort) begin
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  ccff_loader_shifter #(
    .WORD_W (WORD_W),
    .BITS_W (BITS_W)
  ) u_shifter (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .load      (accept_s),
    .shift     (shift_en_r),
    .clear     (clear_s),
    .data      (cfg_data),
    .load_bits (load_bits_s),
    .tail      (ccff_tail),
    .head      (ccff_head),
    .last_bit  (last_bit_s),
    .parity    (tail_parity)
  );

  assign shift_en  = shift_en_r;
  assign cfg_ready = cfg_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: a 52-bit chain model sits on the serial
// port, loads push expectations, and a monitor checks every done pulse.
module tb_ccff_loader;

  localparam int WW = 8;
  localparam int CL = 52;
  localparam int NW = (CL + WW - 1) / WW;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, ccff_head, ccff_tail, shift_en, busy, done, tail_parity;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .shift_en(shift_en),
    .busy(busy), .done(done), .tail_parity(tail_parity)
  );

  // Downstream chain: shifts toward the tail whenever shift_en is high.
  logic [CL-1:0] chain = '0;
  logic          preload_req = 1'b0;
  logic [CL-1:0] preload_val = '0;
  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  typedef struct {
    logic [CL-1:0] chain;
    logic          parity;
    int            lat;
    int            nwords;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] wq[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            shifts = 0;
  int            words_acc = 0;
  bit            active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc_step();
    @(posedge prog_clk);
    #1;
  endtask

  // Reference: the first CL bits of the stream, MSB first; bit 0 ends at the tail.
  function automatic logic [CL-1:0] exp_chain();
    logic [CL-1:0] r;
    logic [WW-1:0] w;
    r = '0;
    for (int i = 0; i < CL; i++) begin
      w = wq[i / WW];
      r[CL-1-i] = w[WW-1-(i % WW)];
    end
    return r;
  endfunction

  // Monitor: tracks each load from start and checks it when done pulses.
  always @(negedge prog_clk) begin
    exp_t e;
    if (!pReset_n) begin
      active = 1'b0;
    end else begin
      if (active) cyc++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("done_latency", 64'(cyc), 64'(e.lat));
          check("shift_count", 64'(shifts), 64'(CL));
          check("word_count", 64'(words_acc), 64'(e.nwords));
          check("chain_contents", 64'(chain), 64'(e.chain));
          check("tail_parity", 64'(tail_parity), 64'(e.parity));
        end
        active = 1'b0;
      end
      if (shift_en) shifts++;
      if (cfg_valid && cfg_ready) words_acc++;
      if (abort) begin
        active = 1'b0;
      end else if (start && !busy) begin
        active = 1'b1;
        cyc = 0;
        shifts = 0;
        words_acc = 0;
      end
    end
  end

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    cyc_step();
    preload_req = 1'b0;
  endtask

  task automatic rand_words();
    wq.delete();
    for (int i = 0; i < NW; i++) wq.push_back(WW'($urandom));
  endtask

  task automatic check_reset_outputs();
    check("rst_shift_en", 64'(shift_en), 64'd0);
    check("rst_head", 64'(ccff_head), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_parity", 64'(tail_parity), 64'd0);
  endtask

  // mode 0: full load, 1: abort on shift 20, 2: reset on shift 30
  task automatic run_load(input int mode, input int gap_idx, input int gap_len, input bit busy_starts);
    int   w = 0;
    int   gapleft = gap_len;
    int   budget = 0;
    bit   hs;
    bit   finished = 1'b0;
    exp_t e;
    if (mode == 0) begin
      e.chain  = exp_chain();
      e.parity = ^chain;
      e.lat    = 1 + NW + CL + gap_len;
      e.nwords = NW;
      sb.push_back(e);
    end
    start = 1'b1;
    cyc_step();
    start = 1'b0;
    while (!finished && budget < 400) begin
      budget++;
      if (mode == 1 && shift_en && shifts >= 20) begin
        abort = 1'b1;
        cyc_step();
        abort = 1'b0;
        check("abort_shift_en", 64'(shift_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(cfg_ready), 64'd0);
        finished = 1'b1;
      end else if (mode == 2 && shift_en && shifts >= 30) begin
        #2;
        pReset_n = 1'b0;
        #1;
        check_reset_outputs();
        cyc_step();
        pReset_n = 1'b1;
        finished = 1'b1;
      end else if (w == NW && !busy) begin
        finished = 1'b1;
      end else begin
        if (w < NW) begin
          cfg_data = wq[w];
          if (w == gap_idx && gapleft > 0) begin
            cfg_valid = 1'b0;
            if (cfg_ready) begin
              gapleft--;
              check("gap_shift_en", 64'(shift_en), 64'd0);
            end
          end else begin
            cfg_valid = 1'b1;
          end
        end else begin
          cfg_valid = 1'b0;
          cfg_data  = WW'($urandom);
        end
        start = busy_starts && busy && ($urandom_range(0, 3) == 0);
        hs = cfg_valid && cfg_ready;
        cyc_step();
        if (hs) w++;
      end
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    if (!finished) check("load_timeout", 64'd0, 64'd1);
    repeat (3) cyc_step();
  endtask

  initial begin
    logic [CL-1:0] v;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge prog_clk);
    #1;
    pReset_n = 1'b1;

    // Streaming load with the reference word stream.
    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h9F};
    preload({20'($urandom), 32'($urandom)});
    run_load(0, -1, 0, 1'b0);

    // Back-pressure: five idle FETCH cycles before word 3.
    preload({20'($urandom), 32'($urandom)});
    run_load(0, 3, 5, 1'b0);

    // Parity of a chain holding exactly 13 ones.
    v = '0;
    while ($countones(v) < 13) v[$urandom_range(0, CL-1)] = 1'b1;
    preload(v);
    rand_words();
    run_load(0, -1, 0, 1'b0);
    check("parity_13_ones", 64'(tail_parity), 64'd1);

    // start together with abort in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    cyc_step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_ready", 64'(cfg_ready), 64'd0);

    rand_words();
    run_load(1, -1, 0, 1'b0);
    rand_words();
    run_load(2, -1, 0, 1'b0);
    rand_words();
    run_load(0, -1, 0, 1'b0);
    rand_words();
    run_load(0, -1, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      preload({20'($urandom), 32'($urandom)});
      rand_words();
      run_load(0, int'($urandom_range(0, NW-1)), int'($urandom_range(0, 4)), 1'($urandom));
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
